arch_regfile: RTL and testbench
===============================

Name: arch_regfile

Overview:
- Architectural (committed) integer register file of the out-of-order RISC-V core.
- Holds 32 x 32-bit registers, x0 hardwired to zero.
- Two combinational read ports are addressed by the decoded rs1/rs2 and feed rename/issue with committed operand values.
- Two synchronous write ports are driven by the reorder buffer retire slots.

Parameters:
- XLEN, 32, data width of each register and each data port.
- NUM_REGS, 32, number of architectural registers.
- REG_W, 5, register index width, equal to clog2(NUM_REGS).
- RETIRE_WIDTH, 2, number of retire write ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  REG_W  read port 0 register index.
- rs2  input  REG_W  read port 1 register index.
- retire_reg  input  array[0:RETIRE_WIDTH-1] of REG_W  destination register per retire slot.
- retire_reg_data  input  array[0:RETIRE_WIDTH-1] of XLEN  value to commit per slot.
- retire_valid  input  RETIRE_WIDTH  per-slot write enable; bit i qualifies slot i.
- rs1_data  output  XLEN  value of register rs1.
- rs2_data  output  XLEN  value of register rs2.

Behaviour:
- Storage: regs[0..NUM_REGS-1], each XLEN bits. regs[0] reads as 0 at all times and is never written.
- Reset: on a rising edge with rst=1, all registers are set to 0. Reset overrides any retire writes in the same cycle. No retire write is performed while rst=1.
- Write: on a rising edge with rst=0, for each slot i with retire_valid[i]=1 and retire_reg[i]!=0, regs[retire_reg[i]] <= retire_reg_data[i].
  - Writes to x0 are silently dropped.
  - Bits of retire_valid that are 0 cause no state change, regardless of the other slot inputs.
- Same-register conflict: if both slots are valid and target the same nonzero register, slot 1 wins. Slot 1 is the younger instruction in program order, so after the edge the register holds retire_reg_data[1].
- Read: rs1_data and rs2_data are purely combinational with zero latency.
  - Each output is 0 when its index is 0; otherwise it is regs[index], subject to the bypass rule in the Optional Feature section.
  - Both ports may address the same register.
- Outputs during reset: reads continue combinationally. Before the first reset edge, values are undefined (X allowed). After the reset edge, every read returns 0 until a retire write occurs.
- No stall or handshake; a write completes on every enabled edge. Back-to-back writes to the same register on consecutive cycles are legal; the last write wins.
- Out-of-range indices cannot occur, because NUM_REGS = 2^REG_W.

Optional Feature:
- Macro ARF_BYPASS_EN controls write-to-read bypassing.
- Defined: a read port whose nonzero index matches a valid retire slot in the current cycle returns that slot's retire_reg_data combinationally, in the same cycle. If both slots match, slot 1's data is returned, consistent with the write priority. rst=1 suppresses the bypass, so the output is the stored value.
- Not defined: reads return only the stored regs value. Data retired in cycle N becomes visible to reads in cycle N+1.

Decomposition:
- Shared package core_pkg holds XLEN, NUM_ARCH_REGS, ARCH_REG_W, RETIRE_WIDTH, and the typedefs arch_reg_t (logic [ARCH_REG_W-1:0]) and word_t (logic [XLEN-1:0]). The same package is used by decode, rename and the ROB.
- One natural sub-module, arf_read_port: a single read port containing the x0 zeroing and, under ARF_BYPASS_EN, the bypass mux. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset: hold rst=1 for one edge, then read rs1=5 and rs2=31. Required: rs1_data=0 and rs2_data=0.
- Single write: slot 0 valid, retire_reg[0]=2, data 0x00000006, one edge. Required: reading rs1=2 returns 0x00000006.
- Dual write, distinct registers: slot 0 writes x3=0x0000000F and slot 1 writes x4=0xDEADBEEF on the same edge. Required: rs1=3 returns 0x0000000F and rs2=4 returns 0xDEADBEEF.
- Conflict and x0: both slots target x7, slot 0 data 0x11 and slot 1 data 0x22. On the next edge, slot 0 writes x0=0xFFFFFFFF. Required: x7 reads 0x22 and x0 reads 0.
- Valid gating and reset priority:
  - retire_valid=2'b00 with retire_reg[0]=2, data 0x99: x2 is unchanged at 0x6.
  - rst=1 together with a valid write of x2=0x55: x2 reads 0 afterwards.
- Bypass: in the same cycle, retire slot 1 writes x9=0xABCD while rs1=9. Required: rs1_data=0xABCD immediately with ARF_BYPASS_EN defined. Without it, rs1_data shows the old value that cycle and 0xABCD after the edge.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core widths and typedefs for decode, rename, ROB and the architectural register file
package core_pkg;
  localparam int XLEN = 32;
  localparam int NUM_ARCH_REGS = 32;
  localparam int ARCH_REG_W = $clog2(NUM_ARCH_REGS);
  localparam int RETIRE_WIDTH = 2;
  typedef logic [ARCH_REG_W-1:0] arch_reg_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/arf_read_port.sv
// arf_read_port: one register read port (idx, stored -> data) with x0 zeroing; ARF_BYPASS_EN adds rst-gated retire bypass, slot 1 highest priority
module arf_read_port
  import core_pkg::*;
(
  input  logic [ARCH_REG_W-1:0] idx,
  input  logic [XLEN-1:0]       stored,
`ifdef ARF_BYPASS_EN
  input  logic                    rst,
  input  logic [ARCH_REG_W-1:0]   retire_reg [0:RETIRE_WIDTH-1],
  input  logic [XLEN-1:0]         retire_reg_data [0:RETIRE_WIDTH-1],
  input  logic [RETIRE_WIDTH-1:0] retire_valid,
`endif
  output logic [XLEN-1:0]       data
);
`ifdef ARF_BYPASS_EN
  always_comb begin
    data = (idx == '0) ? '0 : stored;
    for (int i = 0; i < RETIRE_WIDTH; i++)
      if (!rst && retire_valid[i] && idx != '0 && retire_reg[i] == idx) data = retire_reg_data[i];
  end
`else
  always_comb data = (idx == '0) ? '0 : stored;
`endif
endmodule

// File: rtl/arch_regfile.sv
// arch_regfile: committed 32x32 register file (clk, rst sync high; rs1/rs2 -> rs1_data/rs2_data comb; retire_reg/_data/_valid sync writes, slot 1 wins); ARF_BYPASS_EN enables retire-to-read bypass
module arch_regfile
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ARCH_REG_W-1:0]   rs1,
  input  logic [ARCH_REG_W-1:0]   rs2,
  input  logic [ARCH_REG_W-1:0]   retire_reg [0:RETIRE_WIDTH-1],
  input  logic [XLEN-1:0]         retire_reg_data [0:RETIRE_WIDTH-1],
  input  logic [RETIRE_WIDTH-1:0] retire_valid,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data
);
  word_t regs [0:NUM_ARCH_REGS-1];
  always_ff @(posedge clk)
    if (rst) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < RETIRE_WIDTH; i++)
        if (retire_valid[i] && retire_reg[i] != '0) regs[retire_reg[i]] <= retire_reg_data[i];
    end
  arf_read_port u_rp1 (
    .idx(rs1),
    .stored(regs[rs1]),
`ifdef ARF_BYPASS_EN
    .rst(rst),
    .retire_reg(retire_reg),
    .retire_reg_data(retire_reg_data),
    .retire_valid(retire_valid),
`endif
    .data(rs1_data)
  );
  arf_read_port u_rp2 (
    .idx(rs2),
    .stored(regs[rs2]),
`ifdef ARF_BYPASS_EN
    .rst(rst),
    .retire_reg(retire_reg),
    .retire_reg_data(retire_reg_data),
    .retire_valid(retire_valid),
`endif
    .data(rs2_data)
  );
endmodule

// File: tb/tb_arch_regfile.sv
// tb_arch_regfile: scoreboard-driven self-checking bench for arch_regfile
module tb_arch_regfile;
  import core_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic [ARCH_REG_W-1:0] rs1 = '0, rs2 = '0;
  logic [ARCH_REG_W-1:0] retire_reg [0:RETIRE_WIDTH-1];
  logic [XLEN-1:0] retire_reg_data [0:RETIRE_WIDTH-1];
  logic [RETIRE_WIDTH-1:0] retire_valid = '0;
  logic [XLEN-1:0] rs1_data, rs2_data;
  typedef struct {
    string name;
    logic port;
    word_t exp;
  } sb_t;
  sb_t sb_q [$];
  sb_t e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  arch_regfile dut (
    .clk(clk),
    .rst(rst),
    .rs1(rs1),
    .rs2(rs2),
    .retire_reg(retire_reg),
    .retire_reg_data(retire_reg_data),
    .retire_valid(retire_valid),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (e.port == 1'b0 && rs1_data !== e.exp) begin
        errors++;
        $display("FAIL %s: rs1_data got %h want %h", e.name, rs1_data, e.exp);
      end
      if (e.port == 1'b1 && rs2_data !== e.exp) begin
        errors++;
        $display("FAIL %s: rs2_data got %h want %h", e.name, rs2_data, e.exp);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1;
    edge_step();
    rst = 0;
    rs1 = 5;
    rs2 = 31;
    sb_q.push_back('{"reset_x5", 1'b0, 32'h0});
    sb_q.push_back('{"reset_x31", 1'b1, 32'h0});
    drain();
  endtask
  task automatic test_single_write();
    retire_valid = 2'b01;
    retire_reg[0] = 2;
    retire_reg_data[0] = 32'h6;
    edge_step();
    retire_valid = 2'b00;
    rs1 = 2;
    sb_q.push_back('{"single_x2", 1'b0, 32'h6});
    drain();
  endtask
  task automatic test_dual_write();
    retire_valid = 2'b11;
    retire_reg[0] = 3;
    retire_reg_data[0] = 32'hF;
    retire_reg[1] = 4;
    retire_reg_data[1] = 32'hDEADBEEF;
    edge_step();
    retire_valid = 2'b00;
    rs1 = 3;
    rs2 = 4;
    sb_q.push_back('{"dual_x3", 1'b0, 32'hF});
    sb_q.push_back('{"dual_x4", 1'b1, 32'hDEADBEEF});
    drain();
  endtask
  task automatic test_conflict_x0();
    retire_valid = 2'b11;
    retire_reg[0] = 7;
    retire_reg_data[0] = 32'h11;
    retire_reg[1] = 7;
    retire_reg_data[1] = 32'h22;
    edge_step();
    retire_valid = 2'b01;
    retire_reg[0] = 0;
    retire_reg_data[0] = 32'hFFFFFFFF;
    retire_reg[1] = 8;
    retire_reg_data[1] = 32'h33;
    edge_step();
    retire_valid = 2'b00;
    rs1 = 7;
    rs2 = 0;
    sb_q.push_back('{"conflict_x7", 1'b0, 32'h22});
    sb_q.push_back('{"x0_zero", 1'b1, 32'h0});
    drain();
    rs2 = 8;
    sb_q.push_back('{"invalid_slot1_x8", 1'b1, 32'h0});
    drain();
  endtask
  task automatic test_valid_gating();
    retire_valid = 2'b00;
    retire_reg[0] = 2;
    retire_reg_data[0] = 32'h99;
    retire_reg[1] = 3;
    retire_reg_data[1] = 32'h98;
    edge_step();
    rs1 = 2;
    rs2 = 3;
    sb_q.push_back('{"gated_x2", 1'b0, 32'h6});
    sb_q.push_back('{"gated_x3", 1'b1, 32'hF});
    drain();
  endtask
  task automatic test_back_to_back();
    retire_valid = 2'b01;
    retire_reg[0] = 10;
    retire_reg_data[0] = 32'h1;
    edge_step();
    retire_reg_data[0] = 32'h2;
    edge_step();
    retire_valid = 2'b00;
    rs1 = 10;
    rs2 = 10;
    sb_q.push_back('{"b2b_rs1_x10", 1'b0, 32'h2});
    sb_q.push_back('{"b2b_rs2_x10", 1'b1, 32'h2});
    drain();
  endtask
  task automatic test_reset_priority();
    rst = 1;
    retire_valid = 2'b01;
    retire_reg[0] = 2;
    retire_reg_data[0] = 32'h55;
    edge_step();
    rst = 0;
    retire_valid = 2'b00;
    rs1 = 2;
    rs2 = 10;
    sb_q.push_back('{"rst_prio_x2", 1'b0, 32'h0});
    sb_q.push_back('{"rst_clears_x10", 1'b1, 32'h0});
    drain();
  endtask
  task automatic test_bypass();
    rs1 = 9;
    rs2 = 4;
    retire_valid = 2'b10;
    retire_reg[0] = 9;
    retire_reg_data[0] = 32'h1234;
    retire_reg[1] = 9;
    retire_reg_data[1] = 32'hABCD;
`ifdef ARF_BYPASS_EN
    sb_q.push_back('{"bypass_same_cycle", 1'b0, 32'hABCD});
`else
    sb_q.push_back('{"no_bypass_old", 1'b0, 32'h0});
`endif
    sb_q.push_back('{"bypass_other_port", 1'b1, 32'h0});
    drain();
    edge_step();
    retire_valid = 2'b00;
    sb_q.push_back('{"bypass_after_edge", 1'b0, 32'hABCD});
    drain();
    retire_valid = 2'b11;
    retire_reg[0] = 9;
    retire_reg_data[0] = 32'h5555;
    retire_reg[1] = 9;
    retire_reg_data[1] = 32'h7777;
`ifdef ARF_BYPASS_EN
    sb_q.push_back('{"bypass_slot1_wins", 1'b0, 32'h7777});
`else
    sb_q.push_back('{"no_bypass_stored", 1'b0, 32'hABCD});
`endif
    drain();
    rst = 1;
    sb_q.push_back('{"bypass_rst_suppress", 1'b0, 32'hABCD});
    drain();
    edge_step();
    rst = 0;
    retire_valid = 2'b00;
    sb_q.push_back('{"bypass_rst_cleared", 1'b0, 32'h0});
    drain();
  endtask
  initial begin
    retire_reg[0] = '0;
    retire_reg[1] = '0;
    retire_reg_data[0] = '0;
    retire_reg_data[1] = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_dual_write();
    test_conflict_x0();
    test_valid_gating();
    test_back_to_back();
    test_reset_priority();
    test_bypass();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: entries %0d want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
